instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
Debug-side writer for the instruction memory's load port. It takes a byte stream from the debug UART receiver, assembles 32-bit instruction words MSB-first, and drives the memory's write strobe, write data and write address. It fills consecutive addresses from 0 and stops on an end-of-program word or when memory is full. The block sits in the debug unit between the UART receiver and the instruction memory.

Parameters:
MEM_DEPTH, 32, number of instruction words; the last writable address is MEM_DEPTH-1.
END_WORD, 32'hFFFF_FFFF, end-of-program marker; it is written to memory, then the load ends.
TIMEOUT, 1024, idle cycles allowed inside a partial word before that word is discarded.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
rx_data  input  8  received byte; valid when rx_done=1.
rx_done  input  1  one-cycle strobe meaning one byte is available.
wr_instruction  output  1  memory write strobe; one-cycle pulse per word.
data_instruction  output  32  word to write; stable while wr_instruction=1.
addr_instruction  output  32  word address to write; stable while wr_instruction=1.
loading  output  1  high in RECV and WRITE.
load_done  output  1  high in DONE.
word_count  output  32  number of words written in the current or last load.
error  output  1  sticky; set when a partial word times out.

Behaviour:
- Reset: state IDLE. All outputs 0. Assembly shift register, byte counter (2 bit) and idle counter are 0.
- States are IDLE, RECV, WRITE and DONE.
- IDLE: rx_done is ignored. On start go to RECV and clear addr_instruction, word_count, error, byte counter and idle counter.
- RECV, on rx_done:
  - shift <= {shift[23:0], rx_data}; byte_cnt increments; idle counter clears.
  - On the 4th byte (byte_cnt==3 at the strobe), load data_instruction with the completed word, wrap byte_cnt to 0 and go to WRITE.
- WRITE: lasts exactly one cycle, with wr_instruction=1.
  - data_instruction and addr_instruction are registered, so they are stable for the whole cycle.
  - The memory samples on negedge, half a cycle after the posedge update.
- Latency: rx_done carrying the 4th byte in cycle N gives wr_instruction=1 in cycle N+1.
- Leaving WRITE, word_count increments, then:
  - if data_instruction==END_WORD or addr_instruction==MEM_DEPTH-1, go to DONE with addr unchanged;
  - otherwise addr_instruction increments and the state returns to RECV.
- A byte arriving while in WRITE is accepted into the assembly register as byte 0 of the next word; it is not lost.
- If that WRITE then exits to DONE, the byte is discarded and byte_cnt is cleared.
- Timeout: in RECV with byte_cnt!=0, the idle counter increments each cycle without rx_done. When it reaches TIMEOUT-1:
  - byte_cnt clears, the partial word is dropped and error is set;
  - the state stays RECV and addr_instruction is unchanged.
- The idle counter holds at 0 when byte_cnt==0, so there is no timeout between whole words.
- DONE: load_done=1 and loading=0; rx_done is ignored.
  - start restarts the load as from IDLE, clearing load_done, error and word_count.
- start during RECV or WRITE is ignored.
- Simultaneous start and rx_done in IDLE or DONE: the load starts and that byte is discarded.
- rst asserted mid-load returns everything to reset values immediately. Already-written memory words are not touched.
- wr_instruction is never high for two consecutive cycles.
- wr_instruction is never high outside WRITE.

Test Plan:
1. start, then bytes 00 22 18 20, 00 22 20 22, FF FF FF FF -> writes at addr 0 (0x00221820), addr 1 (0x00222022) and addr 2 (0xFFFFFFFF). Expect load_done=1, word_count=3, error=0, and each wr_instruction exactly 1 cycle after the 4th rx_done.
2. Send 32 non-END words -> last write at addr 31, then DONE with word_count=32. A 33rd word's bytes produce no wr_instruction.
3. start, send 2 bytes, idle 1024 cycles -> error=1, no write. Then send 4 bytes 0x12345678 -> written at addr 0.
4. Mid-word (3 bytes received), assert rst -> all outputs 0, state IDLE. Bytes without start cause no write.
5. Send the 4th byte, then the next word's first byte in the cycle immediately after, i.e. during WRITE -> the second word assembles correctly at addr 1.
6. In DONE, pulse start -> load_done=0, word_count=0, error cleared; the next word is written at addr 0. start pulsed during RECV has no effect on addr.

Source files
------------

// File: rtl/instruction_loader.sv
// Debug-side loader that assembles UART bytes MSB-first into 32-bit words and
// writes them to consecutive instruction-memory addresses starting at 0.
module instruction_loader #(
    parameter int          MEM_DEPTH = 32,
    parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic        wr_instruction,
    output logic [31:0] data_instruction,
    output logic [31:0] addr_instruction,
    output logic        loading,
    output logic        load_done,
    output logic [31:0] word_count,
    output logic        error
);

    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [31:0]       ADDR_LAST = 32'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [31:0]         shift_q, shift_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         word_count_q, word_count_d;
    logic                error_q, error_d;

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        data_d       = data_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        error_d      = error_q;

        case (state_q)
            IDLE, DONE: begin
                // A byte arriving with start is dropped: the fresh load begins empty.
                if (start) begin
                    state_d      = RECV;
                    shift_d      = '0;
                    byte_cnt_d   = '0;
                    idle_cnt_d   = '0;
                    addr_d       = '0;
                    word_count_d = '0;
                    error_d      = 1'b0;
                end
            end
            RECV: begin
                if (rx_done) begin
                    shift_d    = {shift_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    idle_cnt_d = '0;
                    if (byte_cnt_q == 2'd3) begin
                        data_d  = {shift_q[23:0], rx_data};
                        state_d = WRITE;
                    end
                end else if (byte_cnt_q != 2'd0) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        byte_cnt_d = '0;
                        idle_cnt_d = '0;
                        error_d    = 1'b1;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                word_count_d = word_count_q + 32'd1;
                idle_cnt_d   = '0;
                // The first byte of the next word may already arrive here.
                if (rx_done) begin
                    shift_d    = {shift_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                end
                if (data_q == END_WORD || addr_q == ADDR_LAST) begin
                    state_d    = DONE;
                    byte_cnt_d = '0;
                end else begin
                    addr_d  = addr_q + 32'd1;
                    state_d = RECV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            error_q      <= error_d;
        end
    end

    assign wr_instruction   = (state_q == WRITE);
    assign loading          = (state_q == RECV) || (state_q == WRITE);
    assign load_done        = (state_q == DONE);
    assign data_instruction = data_q;
    assign addr_instruction = addr_q;
    assign word_count       = word_count_q;
    assign error            = error_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: expected writes are queued as
// stimulus is driven and compared when the write strobe appears.
module tb_instruction_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        wr_instruction;
    logic [31:0] data_instruction;
    logic [31:0] addr_instruction;
    logic        loading;
    logic        load_done;
    logic [31:0] word_count;
    logic        error;

    instruction_loader dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .rx_data          (rx_data),
        .rx_done          (rx_done),
        .wr_instruction   (wr_instruction),
        .data_instruction (data_instruction),
        .addr_instruction (addr_instruction),
        .loading          (loading),
        .load_done        (load_done),
        .word_count       (word_count),
        .error            (error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_addr = '0;
    logic        prev_wr = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_instruction) begin
            check("wr_single_cycle", {63'd0, prev_wr}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_wr", {32'd0, addr_instruction}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", {32'd0, addr_instruction}, {32'd0, e.addr});
                check("wr_data", {32'd0, data_instruction}, {32'd0, e.data});
                check("wr_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        prev_wr <= wr_instruction;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // All driving tasks start and end 1 ns after a rising edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
    endtask

    // Bytes are back-to-back, so a following word's first byte lands in WRITE.
    task automatic send_word(input logic [31:0] w, input bit expect_wr);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 3; i >= 0; i--) begin
            send_byte(tmp[8*i +: 8]);
        end
        if (expect_wr) begin
            sb.push_back('{addr: exp_addr, data: w, cyc: cyc});
            exp_addr = exp_addr + 32'd1;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rx_data = '0;
        rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_wr", {63'd0, wr_instruction}, 64'd0);
        check("rst_data", {32'd0, data_instruction}, 64'd0);
        check("rst_addr", {32'd0, addr_instruction}, 64'd0);
        check("rst_loading", {63'd0, loading}, 64'd0);
        check("rst_done", {63'd0, load_done}, 64'd0);
        check("rst_count", {32'd0, word_count}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);

        // Start together with a byte: that byte must be dropped.
        start = 1'b1;
        rx_data = 8'h99;
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rx_done = 1'b0;
        exp_addr = '0;
        check("t1_loading", {63'd0, loading}, 64'd1);

        send_word(32'h0022_1820, 1'b1);
        send_word(32'h0022_2022, 1'b1);
        send_word(32'hFFFF_FFFF, 1'b1);
        send_byte(8'h5A);
        wait_cycles(2);
        check("t1_done", {63'd0, load_done}, 64'd1);
        check("t1_loading_off", {63'd0, loading}, 64'd0);
        check("t1_count", {32'd0, word_count}, 64'd3);
        check("t1_error", {63'd0, error}, 64'd0);
        check("t1_addr_hold", {32'd0, addr_instruction}, 64'd2);

        send_word(32'hDEAD_BEEF, 1'b0);
        wait_cycles(2);
        check("done_ignores_rx", {32'd0, word_count}, 64'd3);

        // Restart from DONE and fill memory; start mid-load must be ignored.
        pulse_start();
        exp_addr = '0;
        check("t6_done_clr", {63'd0, load_done}, 64'd0);
        check("t6_count_clr", {32'd0, word_count}, 64'd0);
        check("t6_addr_clr", {32'd0, addr_instruction}, 64'd0);
        for (int i = 0; i < 32; i++) begin
            send_word(32'h1000_0000 + 32'(i * 32'h0101_0101), 1'b1);
            if (i == 5) begin
                wait_cycles(1);
                pulse_start();
                check("t6_start_in_recv", {32'd0, addr_instruction}, 64'd6);
            end
        end
        wait_cycles(2);
        check("t2_done", {63'd0, load_done}, 64'd1);
        check("t2_count", {32'd0, word_count}, 64'd32);
        check("t2_last_addr", {32'd0, addr_instruction}, 64'd31);
        send_word(32'h0BAD_0BAD, 1'b0);
        wait_cycles(2);
        check("t2_no_33rd", {32'd0, word_count}, 64'd32);

        // Partial word timeout, then recovery at the same address.
        pulse_start();
        exp_addr = '0;
        send_byte(8'hAA);
        send_byte(8'hBB);
        wait_cycles(900);
        check("t3_no_early_err", {63'd0, error}, 64'd0);
        wait_cycles(200);
        check("t3_error", {63'd0, error}, 64'd1);
        check("t3_still_loading", {63'd0, loading}, 64'd1);
        check("t3_no_write", {32'd0, word_count}, 64'd0);
        send_word(32'h1234_5678, 1'b1);
        wait_cycles(3);
        send_word(32'hA1B2_C3D4, 1'b1);
        send_word(32'h0BAD_F00D, 1'b1);
        wait_cycles(2);
        check("t5_count", {32'd0, word_count}, 64'd3);
        send_word(32'hFFFF_FFFF, 1'b1);
        wait_cycles(2);
        check("t3_err_sticky", {63'd0, error}, 64'd1);
        check("t3_done", {63'd0, load_done}, 64'd1);
        pulse_start();
        exp_addr = '0;
        check("t6_err_clr", {63'd0, error}, 64'd0);

        // Reset mid-word, then bytes without start.
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        rst = 1'b1;
        #1;
        check("t4_loading", {63'd0, loading}, 64'd0);
        check("t4_done", {63'd0, load_done}, 64'd0);
        check("t4_count", {32'd0, word_count}, 64'd0);
        check("t4_data", {32'd0, data_instruction}, 64'd0);
        check("t4_addr", {32'd0, addr_instruction}, 64'd0);
        check("t4_wr", {63'd0, wr_instruction}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send_word(32'h0404_0404, 1'b0);
        wait_cycles(3);
        check("t4_idle_ignores", {63'd0, loading}, 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
